// File: rtl/clock_div_ctrl_pkg.sv
// Shared constants and state encoding for the divide-ratio change controller.
// The divider's own reset value is taken from DIV_DEFAULT_N so the two cannot drift apart.
package clock_div_ctrl_pkg;

  localparam int              DIV_SIZE          = 3;
  localparam logic [DIV_SIZE-1:0] DIV_DEFAULT_N = 3'b010;
  localparam int              DIV_SETTLE_CYCLES = 4 * (2 ** DIV_SIZE);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    SETTLE = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/clock_div_ctrl_if.sv
// Request/ack bus between the two N requesters and the divide-ratio controller,
// plus the controller's view of the divider N input and status.
interface clock_div_ctrl_if
  import clock_div_ctrl_pkg::*;
#(
  parameter int SIZE = DIV_SIZE
);

  logic            req_a;
  logic [SIZE-1:0] n_a;
  logic            ack_a;
  logic            req_b;
  logic [SIZE-1:0] n_b;
  logic            ack_b;
  logic [SIZE-1:0] div_n;
  logic            busy;
  logic            last_owner;

  modport master (
    output req_a, n_a, req_b, n_b,
    input  ack_a, ack_b, div_n, busy, last_owner
  );

  modport slave (
    input  req_a, n_a, req_b, n_b,
    output ack_a, ack_b, div_n, busy, last_owner
  );

endinterface

// File: rtl/clock_div_ctrl.sv
// Divide-ratio change controller: round-robin arbitration between requesters A and B,
// drives the registered divider N value, holds it stable for SETTLE_CYCLES while the
// divider re-synchronises, then acks the winner for one cycle.
module clock_div_ctrl
  import clock_div_ctrl_pkg::*;
#(
  parameter int              SIZE          = DIV_SIZE,
  parameter logic [SIZE-1:0] DEFAULT_N     = DIV_DEFAULT_N,
  parameter int              SETTLE_CYCLES = DIV_SETTLE_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  clock_div_ctrl_if.slave  bus
);

  localparam int              CNT_W    = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_t            state_q, state_d;
  logic [SIZE-1:0]   div_n_q, div_n_d;
  logic [SIZE-1:0]   n_lat_q, n_lat_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_owner_q, last_owner_d;
  logic              grant_b;

  // Next-state, arbitration and register-update decisions.
  always_comb begin
    state_d      = state_q;
    div_n_d      = div_n_q;
    n_lat_d      = n_lat_q;
    cnt_d        = cnt_q;
    last_owner_d = last_owner_q;
    // B wins when it is the only requester, or when both request and A went last.
    grant_b      = bus.req_b && (!bus.req_a || !last_owner_q);

    case (state_q)
      IDLE: begin
        if (bus.req_a || bus.req_b) begin
          n_lat_d      = grant_b ? bus.n_b : bus.n_a;
          last_owner_d = grant_b;
          state_d      = APPLY;
        end
      end
      APPLY: begin
        if (n_lat_q == div_n_q) begin
          // Divider already runs at this ratio: no re-sync needed.
          state_d = DONE;
        end else begin
          div_n_d = n_lat_q;
          cnt_d   = CNT_LOAD;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control registers and the divider N output; reset returns the divider to its default ratio.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      div_n_q      <= DEFAULT_N;
      cnt_q        <= '0;
      last_owner_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      div_n_q      <= div_n_d;
      cnt_q        <= cnt_d;
      last_owner_q <= last_owner_d;
    end
  end

  // Latched winner value; only ever read after a grant has loaded it.
  always_ff @(posedge clk) begin
    n_lat_q <= n_lat_d;
  end

  assign bus.div_n      = div_n_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.last_owner = last_owner_q;
  assign bus.ack_a      = (state_q == DONE) && !last_owner_q;
  assign bus.ack_b      = (state_q == DONE) &&  last_owner_q;

endmodule

// File: tb/tb_clock_div_ctrl.sv
// Bench for clock_div_ctrl: directed requests, expected acks queued by the stimulus and
// checked by an independent monitor (owner, divide value, cycle of the ack).
module tb_clock_div_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  typedef struct {
    logic       owner;
    logic [2:0] n;
    int         at;
  } exp_t;

  exp_t q[$];

  clock_div_ctrl_if #(.SIZE(3)) bus();

  clock_div_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) tick();
  endtask

  task automatic push(input logic owner, input logic [2:0] n, input int at);
    exp_t e;
    e.owner = owner;
    e.n     = n;
    e.at    = at;
    q.push_back(e);
  endtask

  // Monitor: every ack the DUT shows must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (bus.ack_a && bus.ack_b) begin
      total++;
      bad++;
      $display("FAIL both_acks: ack_a=1 ack_b=1 expected at most one (cycle %0d)", cyc);
    end else if (bus.ack_a || bus.ack_b) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_ack: ack_a=%0d ack_b=%0d expected none (cycle %0d)",
                 bus.ack_a, bus.ack_b, cyc);
      end else begin
        e = q.pop_front();
        check("ack_owner", int'(bus.ack_b), int'(e.owner));
        check("ack_div_n", int'(bus.div_n), int'(e.n));
        check("ack_cycle", cyc, e.at);
      end
    end
  end

  // Single request from one requester; req dropped in its ack cycle.
  task automatic do_req(input logic b, input logic [2:0] n, input logic [2:0] cur_n);
    int e;
    int ack_at;
    logic shortc;
    shortc = (n == cur_n);
    if (b) begin bus.req_b = 1'b1; bus.n_b = n; end
    else   begin bus.req_a = 1'b1; bus.n_a = n; end
    e      = cyc + 1;
    ack_at = shortc ? e + 1 : e + 33;
    push(b, n, ack_at);
    tick();
    check("busy_in_apply", int'(bus.busy), 1);
    check("last_owner", int'(bus.last_owner), int'(b));
    tick();
    check("div_n_t_plus_2", int'(bus.div_n), int'(n));
    wait_cyc(ack_at);
    if (b) bus.req_b = 1'b0; else bus.req_a = 1'b0;
    tick();
    tick();
    check("busy_idle_after", int'(bus.busy), 0);
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    bus.req_a = 1'b0;
    bus.req_b = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_div_n", int'(bus.div_n), 2);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_ack_a", int'(bus.ack_a), 0);
    check("rst_ack_b", int'(bus.ack_b), 0);
    check("rst_last_owner", int'(bus.last_owner), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int e;
    reset     = 1'b1;
    bus.req_a = 1'b0;
    bus.req_b = 1'b0;
    bus.n_a   = 3'd0;
    bus.n_b   = 3'd0;
    tick();

    // Reset state and a plain A change 2 -> 3
    do_reset();
    do_req(1'b0, 3'd3, 3'd2);

    // B asks for the current value: short-circuit ack, no settle
    do_req(1'b1, 3'd3, 3'd3);

    // Contention from reset: A first (4), then B (5)
    do_reset();
    bus.req_a = 1'b1; bus.n_a = 3'd4;
    bus.req_b = 1'b1; bus.n_b = 3'd5;
    e = cyc + 1;
    push(1'b0, 3'd4, e + 33);
    push(1'b1, 3'd5, e + 68);
    wait_cyc(e + 1);
    check("cont_first_owner", int'(bus.last_owner), 0);
    wait_cyc(e + 33);
    bus.req_a = 1'b0;
    wait_cyc(e + 68);
    bus.req_b = 1'b0;
    tick();
    tick();

    // Fairness with both held: A,B,A,B using N values 1 and 0
    bus.req_a = 1'b1; bus.n_a = 3'd1;
    bus.req_b = 1'b1; bus.n_b = 3'd0;
    e = cyc + 1;
    push(1'b0, 3'd1, e + 33);
    push(1'b1, 3'd0, e + 68);
    push(1'b0, 3'd1, e + 103);
    push(1'b1, 3'd0, e + 138);
    wait_cyc(e + 138);
    bus.req_a = 1'b0;
    bus.req_b = 1'b0;
    tick();
    tick();

    // A value changes mid-settle and B arrives mid-settle
    bus.req_a = 1'b1; bus.n_a = 3'd6;
    e = cyc + 1;
    push(1'b0, 3'd6, e + 33);
    push(1'b1, 3'd3, e + 68);
    wait_cyc(e + 10);
    bus.n_a   = 3'd7;
    bus.req_b = 1'b1; bus.n_b = 3'd3;
    wait_cyc(e + 20);
    check("midop_div_n_held", int'(bus.div_n), 6);
    check("midop_owner_held", int'(bus.last_owner), 0);
    wait_cyc(e + 32);
    check("midop_div_n_late", int'(bus.div_n), 6);
    wait_cyc(e + 33);
    bus.req_a = 1'b0;
    wait_cyc(e + 35);
    check("midop_b_granted", int'(bus.last_owner), 1);
    wait_cyc(e + 68);
    bus.req_b = 1'b0;
    tick();
    tick();

    // Reset while settling (counter at 10): no ack, default N, idle
    bus.req_a = 1'b1; bus.n_a = 3'd5;
    e = cyc + 1;
    wait_cyc(e + 22);
    check("pre_rst_div_n", int'(bus.div_n), 5);
    check("pre_rst_busy", int'(bus.busy), 1);
    reset     = 1'b1;
    bus.req_a = 1'b0;
    tick();
    reset = 1'b0;
    check("midrst_div_n", int'(bus.div_n), 2);
    check("midrst_busy", int'(bus.busy), 0);
    check("midrst_ack_a", int'(bus.ack_a), 0);
    repeat (40) tick();
    check("midrst_still_idle", int'(bus.busy), 0);

    check("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
